// File: rtl/moving_average_filter_gen.sv
// rtl/moving_average_filter_gen.sv - streaming moving average over 2^LOG2_WINDOW samples
// Circular window buffer with running sum, one-deep result stage and valid/ready on both sides.
module moving_average_filter_gen #(
   parameter int DATA_WIDTH  = 16,
   parameter int LOG2_WINDOW = 3,
   parameter int SIGNED_MODE = 1,
   parameter int ROUND_MODE  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [LOG2_WINDOW:0]   fill_count
);

   localparam int SUM_WIDTH = DATA_WIDTH + LOG2_WINDOW;
   localparam int WINDOW    = 1 << LOG2_WINDOW;
   localparam logic [LOG2_WINDOW:0]  FILL_FULL = (LOG2_WINDOW + 1)'(WINDOW);
   localparam logic [SUM_WIDTH-1:0] ROUND_ADD = (ROUND_MODE != 0) ? SUM_WIDTH'(WINDOW / 2) : '0;

   logic [DATA_WIDTH-1:0]  r_buf [WINDOW];
   logic [LOG2_WINDOW-1:0] r_wr_ptr;
   logic [LOG2_WINDOW:0]   r_fill;
   logic [SUM_WIDTH-1:0]   r_sum;
   logic                   r_s1_valid;
   logic                   r_out_valid;
   logic [DATA_WIDTH-1:0]  r_out_data;

   logic                   w_accept;
   logic                   w_full;
   logic                   w_s2_load;
   logic [SUM_WIDTH-1:0]   w_in_ext;
   logic [SUM_WIDTH-1:0]   w_old_ext;
   logic [SUM_WIDTH-1:0]   w_sum_next;
   logic [LOG2_WINDOW:0]   w_fill_next;
   logic [SUM_WIDTH-1:0]   w_sum_rnd;
   logic                   w_unused_rnd;

   function automatic logic [SUM_WIDTH-1:0] f_ext(input logic [DATA_WIDTH-1:0] d);
      return {{LOG2_WINDOW{(SIGNED_MODE != 0) && d[DATA_WIDTH-1]}}, d};
   endfunction

   assign in_ready    = !flush && (!r_s1_valid || !r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_full      = (r_fill == FILL_FULL);
   assign w_s2_load   = r_s1_valid && (!r_out_valid || out_ready);

   // The oldest sample leaves the sum only once the window is full.
   assign w_in_ext    = f_ext(in_data);
   assign w_old_ext   = w_full ? f_ext(r_buf[r_wr_ptr]) : '0;
   assign w_sum_next  = r_sum + w_in_ext - w_old_ext;
   assign w_fill_next = w_full ? r_fill : r_fill + 1'b1;

   // Dropping the low LOG2_WINDOW bits is the shift; the kept field is exactly
   // DATA_WIDTH wide, so arithmetic and logical shifts give identical bits here.
   assign w_sum_rnd    = r_sum + ROUND_ADD;
   assign w_unused_rnd = ^w_sum_rnd[LOG2_WINDOW-1:0];

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_sum       <= '0;
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_fill      <= '0;
         r_sum       <= '0;
         r_s1_valid  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_sum      <= w_sum_next;
            r_fill     <= w_fill_next;
            r_s1_valid <= (w_fill_next == FILL_FULL);
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end

         if (w_s2_load) begin
            r_out_data  <= w_sum_rnd[SUM_WIDTH-1:LOG2_WINDOW];
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign fill_count = r_fill;

endmodule

// File: tb/tb_moving_average_filter_gen.sv
// tb/tb_moving_average_filter_gen.sv - bench for moving_average_filter_gen
// Five configurations share one stimulus stream; a window/scoreboard model checks each.
module tb_moving_average_filter_gen;

   localparam int NDUT = 5;
   localparam int LG [NDUT] = '{2, 2, 2, 3, 3};
   localparam int SG [NDUT] = '{0, 1, 1, 0, 0};
   localparam int RD [NDUT] = '{0, 1, 0, 0, 1};

   logic clk;
   logic rst_n;
   logic flush;
   logic in_valid;
   logic [15:0] in_data;
   logic out_ready;

   logic [NDUT-1:0]       rdy;
   logic [NDUT-1:0]       ov;
   logic [NDUT-1:0][15:0] od;
   logic [NDUT-1:0][3:0]  fcv;

   int n_tests = 0;
   int n_fail  = 0;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic [LG[g]:0] w_fc;
      moving_average_filter_gen #(
         .DATA_WIDTH(16), .LOG2_WINDOW(LG[g]), .SIGNED_MODE(SG[g]), .ROUND_MODE(RD[g])
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .flush(flush),
         .in_valid(in_valid), .in_ready(rdy[g]), .in_data(in_data),
         .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
         .fill_count(w_fc)
      );
      assign fcv[g] = 4'(w_fc);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: last 8 accepted samples per instance plus expected-output FIFO.
   logic [15:0]     hist [NDUT][8];
   int              cnt [NDUT];
   logic [15:0]     eq [NDUT][8];
   int              eq_wr [NDUT];
   int              eq_rd [NDUT];
   logic [NDUT-1:0] prev_stall;
   logic [15:0]     prev_data [NDUT];
   logic            prev_flush = 1'b0;

   function automatic logic [15:0] model_avg(input int k);
      longint s;
      int w;
      s = 0;
      w = 1 << LG[k];
      for (int j = 0; j < w; j++) begin
         if (SG[k] != 0) s += longint'($signed(hist[k][j]));
         else            s += longint'(hist[k][j]);
      end
      if (RD[k] != 0) s += w / 2;
      s = s >>> LG[k];
      return s[15:0];
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NDUT; k++) begin
         int w;
         w = 1 << LG[k];
         if (!rst_n) begin
            cnt[k] = 0;
            eq_wr[k] = 0;
            eq_rd[k] = 0;
            prev_stall[k] = 1'b0;
         end else begin
            chk("fill_count", fcv[k], (cnt[k] < w) ? cnt[k] : w);
            if (prev_stall[k] && !prev_flush) begin
               chk("hold_valid", ov[k], 1);
               chk("hold_data", od[k], prev_data[k]);
            end
            if (ov[k] && out_ready) begin
               if (eq_rd[k] == eq_wr[k]) chk("unexpected_output", ov[k], 0);
               else begin
                  chk("out_data", od[k], eq[k][eq_rd[k] % 8]);
                  eq_rd[k]++;
               end
            end
            prev_stall[k] = ov[k] && !out_ready;
            prev_data[k]  = od[k];
            if (flush) begin
               cnt[k] = 0;
               eq_rd[k] = eq_wr[k];
            end else if (in_valid && rdy[k]) begin
               for (int j = 7; j > 0; j--) hist[k][j] = hist[k][j-1];
               hist[k][0] = in_data;
               if (cnt[k] < w) cnt[k]++;
               if (cnt[k] == w) begin
                  eq[k][eq_wr[k] % 8] = model_avg(k);
                  eq_wr[k]++;
               end
            end
         end
      end
      prev_flush = flush;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      in_valid = 1'b0;
      step();
      flush = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      in_valid = 1'b1;
      in_data = d;
      step();
   endtask

   initial begin
      logic [15:0] v1 [5];
      v1 = '{16'd4, 16'd8, 16'd12, 16'd16, 16'd20};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk("reset_out_valid", ov[k], 0);
         chk("reset_out_data", od[k], 0);
         chk("reset_fill", fcv[k], 0);
         chk("reset_in_ready", rdy[k], 1);
      end

      // Unsigned W=4 truncating: 4,8,12,16,20 -> 10, 14
      for (int i = 0; i < 5; i++) begin
         send(v1[i]);
         chk("t1_fill", fcv[0], (i < 4) ? i + 1 : 4);
         if (i == 3) chk("t1_latency_low", ov[0], 0);
      end
      chk("t1_first_valid", ov[0], 1);
      chk("t1_first_data", od[0], 10);
      in_valid = 1'b0;
      step();
      chk("t1_second_data", od[0], 14);

      // Signed W=4: -1,-1,-1,-2 -> -1 rounded, -2 truncated
      do_flush();
      send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFE);
      in_valid = 1'b0;
      step();
      chk("t2_signed_round", od[1], 16'hFFFF);
      chk("t2_signed_trunc", od[2], 16'hFFFE);

      // Full scale W=8: 8 x 0xFFFF, then 0 -> 7*0xFFFF/8 = 0xDFFF either way
      do_flush();
      for (int i = 0; i < 8; i++) send(16'hFFFF);
      send(16'h0000);
      chk("t3_valid", ov[3], 1);
      chk("t3_full_trunc", od[3], 16'hFFFF);
      chk("t3_full_round", od[4], 16'hFFFF);
      in_valid = 1'b0;
      step();
      chk("t3_ninth_trunc", od[3], 16'hDFFF);
      chk("t3_ninth_round", od[4], 16'hDFFF);

      // Backpressure
      do_flush();
      out_ready = 1'b1;
      send(16'd100); send(16'd200); send(16'd300); send(16'd400);
      out_ready = 1'b0;
      in_data = 16'd500;
      #1;
      chk("t4_ready_before", rdy[0], 1);
      step();
      chk("t4_ready_drop", rdy[0], 0);
      chk("t4_valid", ov[0], 1);
      chk("t4_data", od[0], 250);
      for (int i = 0; i < 3; i++) begin
         send(16'(600 + 100 * i));
         chk("t4_ready_held", rdy[0], 0);
         chk("t4_data_held", od[0], 250);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(16'(1000 + 37 * i));
      in_valid = 1'b0;
      repeat (3) step();

      // Flush mid-stream
      do_flush();
      for (int i = 1; i <= 6; i++) send(16'(10 * i));
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 16'd999;
      #1;
      chk("t5_ready_in_flush", rdy[0], 0);
      step();
      flush = 1'b0;
      chk("t5_fill", fcv[0], 0);
      chk("t5_valid", ov[0], 0);
      chk("t5_data_hold", od[0], 35);
      send(16'd1); chk("t5_warm1", ov[0], 0);
      send(16'd2); chk("t5_warm2", ov[0], 0);
      send(16'd3); chk("t5_warm3", ov[0], 0);
      send(16'd6); chk("t5_warm4", ov[0], 0);
      in_valid = 1'b0;
      step();
      chk("t5_out_valid", ov[0], 1);
      chk("t5_out_data", od[0], 3);

      // Asynchronous reset mid-stream
      send(16'd7); send(16'd9);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_fill", fcv[0], 0);
      chk("t6_valid", ov[0], 0);
      chk("t6_data", od[0], 0);
      step();
      rst_n = 1'b1;
      #1;

      // Random traffic across pointer wrap
      for (int i = 0; i < 1000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      for (int k = 0; k < NDUT; k++) chk("drained", eq_wr[k] - eq_rd[k], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
